aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
Round sequencer for the AES cipher core datapath. It accepts one block request at a time and issues the initial load/add-round-key step. It then steps the datapath through 10, 12 or 14 rounds according to key length and presents the result with a valid/ready handshake. It also schedules periodic masking-PRNG reseeds every RESEED_RATE completed blocks. It sits between the block-level AES control/register interface and the cipher core.

Parameters:
RESEED_RATE, 64, completed blocks between reseed requests; 0 disables reseeding
CNT_W, 16, width of completed-block counter block_cnt_o

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
in_valid_i  in  1  block request valid
in_ready_o  out  1  controller can accept a request
op_i  in  1  0=encrypt, 1=decrypt; sampled on accept
key_len_i  in  2  0=128b, 1=192b, 2=256b, 3=treated as 128b; sampled on accept
abort_i  in  1  synchronous abort of the block in flight
dp_start_o  out  1  one-cycle pulse: load state, apply round key 0
dp_step_o  out  1  request datapath round dp_round_o; held until dp_ack_i
dp_ack_i  in  1  datapath completed current round
dp_round_o  out  4  current round index, 0 during load
dp_final_o  out  1  current round is the final round (no MixColumns)
dp_op_o  out  1  latched op
out_valid_o  out  1  result available
out_ready_i  in  1  consumer accepts result
reseed_req_o  out  1  PRNG reseed request; held until reseed_ack_i
reseed_ack_i  in  1  reseed done
busy_o  out  1  state != IDLE
block_cnt_o  out  CNT_W  completed blocks since reset; wraps modulo 2^CNT_W

Behaviour:
- All outputs are registered (Moore) except in_ready_o = (state==IDLE).
- Reset:
  - state=IDLE; all outputs 0 except in_ready_o=1.
  - block_cnt_o=0; internal reseed counter=0; dp_round_o=0.
- nrounds is latched on accept: 10 for key_len 0 or 3, 12 for key_len 1, 14 for key_len 2.
- States:
  - IDLE:
    - On in_valid_i&in_ready_o, latch op/nrounds and go to LOAD.
    - in_ready_o is 0 in every other state. Back-to-back requests are therefore separated by at least one IDLE cycle.
  - LOAD:
    - Exactly one cycle with dp_start_o=1 and dp_round_o=0.
    - Next: ROUND with dp_round_o=1.
  - ROUND:
    - dp_step_o=1; dp_final_o=(dp_round_o==nrounds).
    - On dp_ack_i, if dp_round_o==nrounds: go to WAIT_OUT with dp_step_o=0 and out_valid_o=1.
    - On dp_ack_i, otherwise: increment dp_round_o and stay.
    - Without dp_ack_i: hold all outputs.
  - WAIT_OUT:
    - out_valid_o held until out_ready_i.
    - On handshake: block_cnt_o++ and reseed counter++.
    - If RESEED_RATE!=0 and the new reseed count==RESEED_RATE: clear the reseed counter and go to RESEED.
    - Otherwise go to IDLE.
  - RESEED:
    - reseed_req_o=1 until reseed_ack_i, then go to IDLE.
    - reseed_ack_i outside RESEED is ignored.
- Latency with dp_ack_i tied high:
  - Request accepted at edge T: LOAD during cycle T+1, rounds 1..nrounds during cycles T+2..T+1+nrounds.
  - out_valid_o rises in cycle T+2+nrounds: T+12, T+14 or T+16.
- Abort:
  - abort_i in LOAD, ROUND or WAIT_OUT forces IDLE on the next edge.
  - Clears dp_step_o, dp_final_o and out_valid_o, and sets dp_round_o to 0.
  - block_cnt_o and the reseed counter are unchanged.
  - abort_i is ignored in IDLE and RESEED; a reseed always completes.
- Simultaneous events:
  - abort_i has priority over dp_ack_i and over out_ready_i in the same cycle.
  - in_valid_i while busy is not accepted; the requester must hold it.
- rst_i mid-operation returns to the reset values on the next edge, regardless of state.
- block_cnt_o wraps 2^CNT_W-1 -> 0 silently; the reseed counter is independent of this wrap.

Test Plan:
- Reset then encrypt, key_len=0, dp_ack_i=1, out_ready_i=1: dp_start_o pulses one cycle after accept; dp_round_o steps 1..10; dp_final_o=1 only at round 10; out_valid_o at T+12; block_cnt_o=1.
- key_len=1, then 2, then 3, op=1: 12, 14 and 10 rounds respectively; dp_op_o=1 throughout each block; out_valid_o at T+14, T+16 and T+12.
- dp_ack_i held low 3 cycles at round 5, out_ready_i held low 4 cycles: dp_step_o, dp_round_o=5 and out_valid_o remain stable; in_ready_o=0 throughout; completion is delayed by exactly 3+4 cycles.
- RESEED_RATE=2, three blocks back-to-back: reseed_req_o rises after the 2nd output handshake; it holds until reseed_ack_i is pulsed after 5 cycles; the 3rd request is not accepted until the controller returns to IDLE; with RESEED_RATE=0, reseed_req_o never asserts.
- abort_i at round 7 coincident with dp_ack_i: IDLE next cycle; out_valid_o never asserts; block_cnt_o unchanged; the following request completes normally.
- rst_i asserted during ROUND and during RESEED: all outputs return to reset values next cycle; block_cnt_o=0.

Source files
------------

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl
// Description : AES round sequencer. It accepts one block request at a time
//               and issues the load/add-round-key pulse. It then steps the
//               datapath through 10/12/14 rounds and hands the result over
//               with valid/ready. It requests a masking-PRNG reseed every
//               RESEED_RATE completed blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
  parameter int RESEED_RATE = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             op_i,
  input  logic [1:0]       key_len_i,
  input  logic             abort_i,
  output logic             dp_start_o,
  output logic             dp_step_o,
  input  logic             dp_ack_i,
  output logic [3:0]       dp_round_o,
  output logic             dp_final_o,
  output logic             dp_op_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             reseed_req_o,
  input  logic             reseed_ack_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] block_cnt_o
);

  // The reseed counter only has to reach RESEED_RATE; keep at least one bit
  // so the declaration stays legal when reseeding is disabled.
  localparam int RC_W = (RESEED_RATE > 1) ? $clog2(RESEED_RATE + 1) : 1;
  localparam logic [RC_W-1:0] RESEED_RATE_C = RC_W'(RESEED_RATE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    ROUND    = 3'd2,
    WAIT_OUT = 3'd3,
    RESEED   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [3:0]        nrounds_q, nrounds_d;
  logic [3:0]        round_q, round_d;
  logic              start_q, start_d;
  logic              step_q, step_d;
  logic              final_q, final_d;
  logic              valid_q, valid_d;
  logic              reseed_q, reseed_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [3:0]        nrounds_sel;
  logic [RC_W-1:0]   rcnt_inc;

  // Round count for the requested key length; code 3 behaves as AES-128.
  always_comb begin
    nrounds_sel = 4'd10;
    case (key_len_i)
      2'd1:    nrounds_sel = 4'd12;
      2'd2:    nrounds_sel = 4'd14;
      default: nrounds_sel = 4'd10;
    endcase
  end

  assign rcnt_inc = rcnt_q + 1'b1;

  // Next-state and next-output logic; every output except in_ready_o is registered.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    nrounds_d = nrounds_q;
    round_d   = round_q;
    start_d   = 1'b0;
    step_d    = step_q;
    final_d   = final_q;
    valid_d   = valid_q;
    reseed_d  = reseed_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d   = LOAD;
          op_d      = op_i;
          nrounds_d = nrounds_sel;
          round_d   = 4'd0;
          start_d   = 1'b1;
        end
      end

      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
          round_d = 4'd0;
        end else begin
          state_d = ROUND;
          round_d = 4'd1;
          step_d  = 1'b1;
          final_d = 1'b0;
        end
      end

      ROUND: begin
        // Abort outranks a same-cycle acknowledge.
        if (abort_i) begin
          state_d = IDLE;
          step_d  = 1'b0;
          final_d = 1'b0;
          valid_d = 1'b0;
          round_d = 4'd0;
        end else if (dp_ack_i) begin
          if (round_q == nrounds_q) begin
            state_d = WAIT_OUT;
            step_d  = 1'b0;
            final_d = 1'b0;
            valid_d = 1'b1;
          end else begin
            round_d = round_q + 4'd1;
            final_d = ((round_q + 4'd1) == nrounds_q);
          end
        end
      end

      WAIT_OUT: begin
        // Abort outranks a same-cycle output handshake; counters stay put.
        if (abort_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          round_d = 4'd0;
        end else if (out_ready_i) begin
          valid_d = 1'b0;
          round_d = 4'd0;
          cnt_d   = cnt_q + 1'b1;
          if ((RESEED_RATE != 0) && (rcnt_inc == RESEED_RATE_C)) begin
            rcnt_d   = '0;
            state_d  = RESEED;
            reseed_d = 1'b1;
          end else begin
            rcnt_d  = rcnt_inc;
            state_d = IDLE;
          end
        end
      end

      RESEED: begin
        // A reseed always runs to completion; abort is not looked at here.
        if (reseed_ack_i) begin
          reseed_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      nrounds_q <= 4'd10;
      round_q   <= 4'd0;
      start_q   <= 1'b0;
      step_q    <= 1'b0;
      final_q   <= 1'b0;
      valid_q   <= 1'b0;
      reseed_q  <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      nrounds_q <= nrounds_d;
      round_q   <= round_d;
      start_q   <= start_d;
      step_q    <= step_d;
      final_q   <= final_d;
      valid_q   <= valid_d;
      reseed_q  <= reseed_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign in_ready_o   = (state_q == IDLE);
  assign dp_start_o   = start_q;
  assign dp_step_o    = step_q;
  assign dp_round_o   = round_q;
  assign dp_final_o   = final_q;
  assign dp_op_o      = op_q;
  assign out_valid_o  = valid_q;
  assign reseed_req_o = reseed_q;
  assign busy_o       = busy_q;
  assign block_cnt_o  = cnt_q;

endmodule
`default_nettype wire
